// File: rtl/dino_pkg.sv
// Shared definitions for the dino game pipeline: game state encoding, speed
// divisor width and the BCD score helpers used by speed_ctrl and the layers.
package dino_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OVER = 2'd2
  } game_state_t;

  localparam int SPEED_W = 21;
  localparam logic [SPEED_W-1:0] SPEED_STALL = 21'h1FFFFF;
  localparam int SCORE_DIGITS = 4;
  localparam int SCORE_W = 4 * SCORE_DIGITS;

  // Ripple a +1 through the BCD digits, least significant first.
  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    logic carry;
    r     = v;
    carry = 1'b1;
    for (int d = 0; d < SCORE_DIGITS; d++) begin
      if (carry) begin
        if (v[d*4 +: 4] == 4'd9) begin
          r[d*4 +: 4] = 4'd0;
        end else begin
          r[d*4 +: 4] = v[d*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_counter4.sv
// Four-digit BCD score counter: synchronous clear, increment, and hold at 9999.
// hundreds_wrap flags that the next increment lands on a multiple of 100.
module bcd_counter4
  import dino_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr,
  input  logic               inc,
  output logic [SCORE_W-1:0] value,
  output logic               hundreds_wrap,
  output logic               saturated
);

  assign saturated     = (value == 16'h9999);
  assign hundreds_wrap = (value[7:0] == 8'h99) && !saturated;

  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of the others; blocking here would create ordering races.
  always_ff @(posedge clk) begin
    if (rstn) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && !saturated) begin
      value <= bcd_inc(value);
    end
  end

endmodule

// File: rtl/speed_ctrl.sv
// Game-pace controller: IDLE/RUN/OVER FSM, BCD score and the scroll divisor.
// Define SPEED_CTRL_HISCORE_EN to keep a best-score register on hiscore.
module speed_ctrl
  import dino_pkg::*;
#(
  parameter logic [SPEED_W-1:0] INIT_SPEED   = 21'd400000,
  parameter logic [SPEED_W-1:0] MIN_SPEED    = 21'd150000,
  parameter logic [SPEED_W-1:0] SPEED_STEP   = 21'd10000,
  parameter logic [23:0]        SCORE_PERIOD = 24'd10000000
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               collide,
  output logic [SPEED_W-1:0] speed,
  output logic               running,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hiscore,
  output logic               score_tick
);

  game_state_t        state, state_nxt;
  logic               start_q;
  logic               start_edge;
  logic [23:0]        period_cnt, period_cnt_nxt;
  logic [SPEED_W-1:0] speed_reg, speed_reg_nxt, speed_dec;
  logic [SPEED_W:0]   speed_diff;
  logic               score_clr, score_inc, tick_nxt;
  logic               hundreds_wrap, saturated;

  assign start_edge = start && !start_q;

  // One extra bit catches the borrow when the step exceeds the current divisor.
  assign speed_diff = {1'b0, speed_reg} - {1'b0, SPEED_STEP};
  assign speed_dec  = (speed_diff[SPEED_W] || (speed_diff[SPEED_W-1:0] < MIN_SPEED))
                    ? MIN_SPEED : speed_diff[SPEED_W-1:0];

  bcd_counter4 u_score (
    .clk          (clk),
    .rstn         (rstn),
    .clr          (score_clr),
    .inc          (score_inc),
    .value        (score),
    .hundreds_wrap(hundreds_wrap),
    .saturated    (saturated)
  );

  always_ff @(posedge clk) begin
    if (rstn) state <= IDLE;
    else      state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt      = state;
    period_cnt_nxt = period_cnt;
    speed_reg_nxt  = speed_reg;
    score_clr      = 1'b0;
    score_inc      = 1'b0;
    tick_nxt       = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (start_edge) begin
          state_nxt      = RUN;
          score_clr      = 1'b1;
          period_cnt_nxt = '0;
          speed_reg_nxt  = INIT_SPEED;
        end
      end
      RUN: begin
        // A collision pre-empts any score-period wrap in the same cycle.
        if (collide) begin
          state_nxt = OVER;
        end else if (period_cnt == SCORE_PERIOD - 24'd1) begin
          period_cnt_nxt = '0;
          if (!saturated) begin
            score_inc = 1'b1;
            tick_nxt  = 1'b1;
            if (hundreds_wrap) speed_reg_nxt = speed_dec;
          end
        end else begin
          period_cnt_nxt = period_cnt + 24'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      start_q    <= 1'b0;
      period_cnt <= '0;
      speed_reg  <= INIT_SPEED;
      score_tick <= 1'b0;
      speed      <= SPEED_STALL;
      running    <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      start_q    <= start;
      period_cnt <= period_cnt_nxt;
      speed_reg  <= speed_reg_nxt;
      score_tick <= tick_nxt;
      speed      <= (state_nxt == RUN) ? speed_reg_nxt : SPEED_STALL;
      running    <= (state_nxt == RUN);
      game_over  <= (state_nxt == OVER);
    end
  end

`ifdef SPEED_CTRL_HISCORE_EN
  logic [SCORE_W-1:0] hiscore_q;

  // Score is frozen on the collide cycle, so it can be compared directly.
  always_ff @(posedge clk) begin
    if (rstn) begin
      hiscore_q <= '0;
    end else if (state == RUN && state_nxt == OVER && score > hiscore_q) begin
      hiscore_q <= score;
    end
  end

  assign hiscore = hiscore_q;
`else
  assign hiscore = '0;
`endif

endmodule

// File: tb/tb_speed_ctrl.sv
// Self-checking bench for speed_ctrl: a score/age based reference model
// predicts every output; speed is derived from score with plain arithmetic.
module tb_speed_ctrl;

  localparam int PERIOD = 4;
  localparam int INIT   = 100;
  localparam int STEP   = 30;
  localparam int MIN    = 20;
  localparam logic [20:0] STALL = 21'h1FFFFF;
`ifdef SPEED_CTRL_HISCORE_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        start = 1'b0;
  logic        collide = 1'b0;
  logic [20:0] speed;
  logic        running, game_over, score_tick;
  logic [15:0] score, hiscore;

  speed_ctrl #(
    .INIT_SPEED  (21'd100),
    .MIN_SPEED   (21'd20),
    .SPEED_STEP  (21'd30),
    .SCORE_PERIOD(24'd4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .collide   (collide),
    .speed     (speed),
    .running   (running),
    .game_over (game_over),
    .score     (score),
    .hiscore   (hiscore),
    .score_tick(score_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum {M_IDLE, M_RUN, M_OVER} phase_t;
  phase_t m_phase   = M_IDLE;
  int     m_score   = 0;
  int     m_hi      = 0;
  int     m_age     = 0;
  bit     m_tick    = 1'b0;
  bit     m_start_q = 1'b0;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [20:0] exp_speed();
    int v;
    if (m_phase != M_RUN) return STALL;
    v = INIT - STEP * (m_score / 100);
    if (v < MIN) v = MIN;
    return 21'(v);
  endfunction

  // Advance DUT and model by one clock; outputs are stable on return.
  task automatic cycle();
    bit edge_s;
    @(posedge clk);
    edge_s = start && !m_start_q;
    if (rstn) begin
      m_phase = M_IDLE; m_score = 0; m_hi = 0; m_age = 0;
      m_tick = 1'b0; m_start_q = 1'b0;
    end else begin
      m_tick = 1'b0;
      if (m_phase == M_RUN) begin
        if (collide) begin
          m_phase = M_OVER;
          if (HI_EN && m_score > m_hi) m_hi = m_score;
        end else begin
          m_age++;
          if (m_age % PERIOD == 0 && m_score < 9999) begin
            m_score++;
            m_tick = 1'b1;
          end
        end
      end else if (edge_s) begin
        m_phase = M_RUN; m_score = 0; m_age = 0;
      end
      m_start_q = start;
    end
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b1; start = 1'b0; collide = 1'b0;
    cycle(); cycle();
    n_checks++;
    if (speed !== STALL) begin n_fail++; $display("FAIL reset_speed got %h want %h", speed, STALL); end
    n_checks++;
    if (score !== 16'h0) begin n_fail++; $display("FAIL reset_score got %h want 0000", score); end
    n_checks++;
    if (hiscore !== 16'h0) begin n_fail++; $display("FAIL reset_hiscore got %h want 0000", hiscore); end
    n_checks++;
    if ({running, game_over, score_tick} !== 3'b000)
      begin n_fail++; $display("FAIL reset_flags got %b want 000", {running, game_over, score_tick}); end
    rstn = 1'b0;
  endtask

  task automatic test_start_hold();
    int   rises = 0;
    logic prev_run = running;
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (running && !prev_run) rises++;
      prev_run = running;
      n_checks++;
      if (running !== (m_phase == M_RUN))
        begin n_fail++; $display("FAIL hold_running cyc %0d got %b want %b", i, running, m_phase == M_RUN); end
      n_checks++;
      if (score_tick !== m_tick)
        begin n_fail++; $display("FAIL hold_tick cyc %0d got %b want %b", i, score_tick, m_tick); end
      if (i == 0) begin
        n_checks++;
        if (speed !== 21'd100) begin n_fail++; $display("FAIL start_speed got %0d want 100", speed); end
      end
    end
    start = 1'b0;
    n_checks++;
    if (rises != 1) begin n_fail++; $display("FAIL hold_one_start got %0d rises want 1", rises); end
    for (int i = 0; i < 12; i++) begin
      cycle();
      n_checks++;
      if (score_tick !== m_tick || score !== to_bcd(m_score))
        begin n_fail++; $display("FAIL tick_period got tick %b score %h want tick %b score %h",
                                 score_tick, score, m_tick, to_bcd(m_score)); end
    end
  endtask

  task automatic test_speed_steps();
    int bound = 0;
    while (!(m_score == 400 && m_tick) && bound < 3000) begin
      cycle();
      bound++;
      n_checks++;
      if (speed !== exp_speed() || score !== to_bcd(m_score))
        begin n_fail++; $display("FAIL speed_track got speed %0d score %h want speed %0d score %h",
                                 speed, score, exp_speed(), to_bcd(m_score)); end
      if (m_tick && (m_score == 100 || m_score == 200 || m_score == 300)) begin
        n_checks++;
        if (speed !== ((m_score == 100) ? 21'd70 : (m_score == 200) ? 21'd40 : 21'd20))
          begin n_fail++; $display("FAIL speed_step at %0d got %0d", m_score, speed); end
      end
    end
    n_checks++;
    if (bound >= 3000 || speed !== 21'd20 || score !== 16'h0400)
      begin n_fail++; $display("FAIL speed_floor got speed %0d score %h want 20 0400", speed, score); end
  endtask

  task automatic test_collide_wrap();
    int bound = 0;
    collide = 1'b1; cycle(); collide = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    while (!(m_score == 5 && m_age % PERIOD == PERIOD - 1) && bound < 200) begin
      cycle(); bound++;
    end
    collide = 1'b1; cycle(); collide = 1'b0;
    n_checks++;
    if (score !== 16'h0005 || score_tick !== 1'b0)
      begin n_fail++; $display("FAIL collide_wrap_score got %h tick %b want 0005 0", score, score_tick); end
    n_checks++;
    if (game_over !== 1'b1 || running !== 1'b0 || speed !== STALL)
      begin n_fail++; $display("FAIL collide_wrap_over got over %b run %b speed %h", game_over, running, speed); end
    collide = 1'b1; cycle(); cycle(); collide = 1'b0;
    n_checks++;
    if (game_over !== 1'b1 || score !== 16'h0005)
      begin n_fail++; $display("FAIL collide_in_over got over %b score %h want 1 0005", game_over, score); end
  endtask

  task automatic test_hiscore();
    int targets[2] = '{12, 7};
    rstn = 1'b1; cycle(); rstn = 1'b0;
    foreach (targets[r]) begin
      int bound = 0;
      start = 1'b1; cycle(); start = 1'b0;
      n_checks++;
      if (score !== 16'h0 || speed !== 21'd100 || running !== 1'b1)
        begin n_fail++; $display("FAIL restart got score %h speed %0d run %b want 0000 100 1", score, speed, running); end
      while (m_score != targets[r] && bound < 500) begin cycle(); bound++; end
      collide = 1'b1; cycle(); collide = 1'b0;
      n_checks++;
      if (hiscore !== to_bcd(m_hi) || score !== to_bcd(targets[r]))
        begin n_fail++; $display("FAIL run_end got hi %h score %h want hi %h score %h",
                                 hiscore, score, to_bcd(m_hi), to_bcd(targets[r])); end
    end
    n_checks++;
    if (hiscore !== (HI_EN ? 16'h0012 : 16'h0000))
      begin n_fail++; $display("FAIL hiscore_final got %h want %h", hiscore, HI_EN ? 16'h0012 : 16'h0000); end
  endtask

  task automatic test_saturate();
    int bound = 0;
    start = 1'b1; cycle(); start = 1'b0;
    while (m_score != 9999 && bound < 45000) begin
      cycle(); bound++;
      n_checks++;
      if (score !== to_bcd(m_score) || score_tick !== m_tick || speed !== exp_speed())
        begin n_fail++; $display("FAIL sat_track got %h %b %0d want %h %b %0d", score, score_tick, speed,
                                 to_bcd(m_score), m_tick, exp_speed()); end
    end
    for (int i = 0; i < 40; i++) begin
      cycle();
      n_checks++;
      if (score !== 16'h9999 || score_tick !== 1'b0)
        begin n_fail++; $display("FAIL sat_hold got score %h tick %b want 9999 0", score, score_tick); end
    end
  endtask

  task automatic test_reset_mid();
    int bound = 0;
    collide = 1'b1; cycle(); collide = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    while (m_score != 150 && bound < 1000) begin cycle(); bound++; end
    n_checks++;
    if (score !== 16'h0150) begin n_fail++; $display("FAIL pre_reset_score got %h want 0150", score); end
    rstn = 1'b1; cycle(); rstn = 1'b0;
    n_checks++;
    if ({running, game_over, score_tick} !== 3'b000 || score !== 16'h0 || hiscore !== 16'h0 || speed !== STALL)
      begin n_fail++; $display("FAIL mid_reset got flags %b score %h hi %h speed %h",
                               {running, game_over, score_tick}, score, hiscore, speed); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) start = ~start;
      collide = ($urandom_range(0, 199) == 0);
      rstn    = ($urandom_range(0, 999) == 0);
      cycle();
      n_checks++;
      if (running !== (m_phase == M_RUN) || game_over !== (m_phase == M_OVER) ||
          score !== to_bcd(m_score) || hiscore !== to_bcd(m_hi) ||
          score_tick !== m_tick || speed !== exp_speed())
        begin n_fail++; $display("FAIL random cyc %0d got r%b o%b s%h h%h t%b v%0d want r%b o%b s%h h%h t%b v%0d",
                                 i, running, game_over, score, hiscore, score_tick, speed,
                                 m_phase == M_RUN, m_phase == M_OVER, to_bcd(m_score), to_bcd(m_hi),
                                 m_tick, exp_speed()); end
    end
    rstn = 1'b0; start = 1'b0; collide = 1'b0;
  endtask

  initial begin
    test_reset();
    test_start_hold();
    test_speed_steps();
    test_collide_wrap();
    test_hiscore();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/speed_ctrl.md
# speed_ctrl

Game-pace controller sitting directly upstream of the scrolling layers (cloud, ground, obstacle). Runs the IDLE/RUN/OVER game state machine, counts a 4-digit BCD score, and produces the `speed` divisor that every scrolling layer compares against its own cycle counter. Each scrolling layer moves one step each time its counter reaches `speed`, so a smaller `speed` means faster scrolling. The divisor shrinks as the score grows and is parked at maximum when the game is not running.

## Interface
Parameters:
- `INIT_SPEED`, 21'd400000, divisor loaded at game start.
- `MIN_SPEED`, 21'd150000, floor for the divisor.
- `SPEED_STEP`, 21'd10000, divisor reduction per 100 points.
- `SCORE_PERIOD`, 24'd10000000, clock cycles per score point.

Ports:
- `clk`  in  1  system clock.
- `rstn`  in  1  reset; synchronous, active-high despite the name.
- `start`  in  1  jump/start key, level; the block edge-detects it internally.
- `collide`  in  1  level; obstacle overlap reported by the obstacle layer.
- `speed`  out  21  scroll divisor fed to the layers.
- `running`  out  1  high in RUN only.
- `game_over`  out  1  high in OVER only.
- `score`  out  16  4 BCD digits, [15:12] = thousands.
- `hiscore`  out  16  4 BCD digits, best score so far.
- `score_tick`  out  1  one-cycle pulse when the score increments.

## Operation
- The start edge is `start & ~start_q`, where `start_q` is `start` registered. Holding `start` counts as one edge.
- States:
  - IDLE (reset state): `score` = 0. `start` edge → RUN.
  - RUN: period counter counts 0..SCORE_PERIOD-1. At the wrap it pulses `score_tick`, and `score` increments in BCD, saturating at 9999 (no tick once saturated). `collide` high → OVER.
  - OVER: `score` is frozen. `start` edge → RUN.
- Entering RUN, from IDLE or OVER:
  - `score` clears to 0.
  - The period counter clears to 0.
  - The speed register loads `INIT_SPEED`.
- Speed update: on each increment whose result has the lower two digits at 00 (100, 200, …), the speed register becomes `max(speed - SPEED_STEP, MIN_SPEED)`.
  - The subtraction is computed at 22 bits; a borrow also selects `MIN_SPEED`.
  - The speed register never rises within a run.
- `speed` output = the speed register in RUN; 21'h1FFFFF in IDLE and OVER, so the layers effectively stall.
- Simultaneous events in RUN:
  - `collide` and a score-period wrap in the same cycle: `collide` wins. No increment, no tick, no speed change; the next state is OVER.
  - `collide` and a `start` edge in the same cycle: `collide` wins.
  - `start` in RUN is ignored.
- `collide` is ignored in IDLE and OVER.
- `rstn` mid-game:
  - Next cycle is IDLE.
  - `score` = 0, `hiscore` = 0, speed register = `INIT_SPEED`, `start_q` = 0.
  - `score_tick` = 0.

## Timing
- All outputs are registered.
- Reset values: `speed` = 21'h1FFFFF, `running` = 0, `game_over` = 0, `score` = 0, `hiscore` = 0, `score_tick` = 0.
- `start` rises in cycle N → `running` = 1 and `speed` = `INIT_SPEED` from cycle N+1.
- RUN entered in cycle N → first `score_tick` in cycle N+SCORE_PERIOD, with `score` updated in the same cycle.
- `collide` sampled high in cycle N → `running` = 0, `game_over` = 1, `speed` = 21'h1FFFFF from cycle N+1.
- A speed reduction appears in the same cycle as the `score_tick` that reaches a multiple of 100.

## Configuration
- `SPEED_CTRL_HISCORE_EN` defined:
  - On the RUN→OVER transition, `hiscore` ← `score` if `score` > `hiscore` (BCD compare is plain unsigned compare).
  - `hiscore` is visible from the first OVER cycle, i.e. the same cycle `game_over` rises.
- `SPEED_CTRL_HISCORE_EN` undefined: the `hiscore` port remains and is tied to 0, and no register is inferred.

## Structure
- Shared package `dino_pkg` holds:
  - the state typedef (IDLE/RUN/OVER);
  - `SPEED_W` = 21;
  - `SPEED_STALL` = 21'h1FFFFF;
  - `SCORE_DIGITS` = 4.
  The layer modules use the same `SPEED_W`.
- One sub-module: `bcd_counter4`. It is a 4-digit BCD incrementer with clear, inc and saturate-at-9999, and outputs the value plus a `hundreds_wrap` flag.

## Test plan
Bench parameters: `SCORE_PERIOD` = 4, `INIT_SPEED` = 100, `SPEED_STEP` = 30, `MIN_SPEED` = 20.
1. Reset, then hold `start` high 10 cycles → exactly one transition to RUN. `speed` = 100 one cycle after the rise; `score_tick` every 4 cycles.
2. Run 400 ticks → `speed` steps 100→70→40→20 at scores 100/200/300, and stays 20 at score 400.
3. Assert `collide` on the same cycle as a score-period wrap at score 0005 → `score` stays 0005 with no tick; next cycle `game_over` = 1 and `speed` = 21'h1FFFFF.
4. With `SPEED_CTRL_HISCORE_EN`: run 1 ends at 0012, run 2 at 0007 → `hiscore` = 0012 after both. Restarting from OVER clears `score` to 0 and sets `speed` back to 100.
5. Force `score` near the limit by running 9999+ ticks → `score` holds at 9999 and `score_tick` stops.
6. Assert `rstn` for one cycle mid-RUN at score 0150 → next cycle IDLE, `score` = 0, `hiscore` = 0, `speed` = 21'h1FFFFF.
